// File: rtl/cep_tx_arbiter_pkg.sv
// Shared definitions for the CEP transmit arbiter: package field positions,
// channel codes and small helpers used by the arbiter.
package cep_tx_arbiter_pkg;

  localparam int CEP_DATA_WIDTH       = 64;
  localparam int CEP_LAST_SUBLINE_LSB = 0;
  localparam int CEP_LAST_SUBLINE_MSB = 1;
  localparam int CEP_IS_REQ           = 4;
  localparam int CEP_IS_RESP          = 5;
  localparam int CEP_IS_INT           = 6;
  localparam int CEP_CH_WIDTH         = 2;

  typedef enum logic [CEP_CH_WIDTH-1:0] {
    CEP_CH_REQ  = 2'd0,
    CEP_CH_RESP = 2'd1,
    CEP_CH_INT  = 2'd2
  } cep_ch_e;

  function automatic logic is_last(input logic [CEP_DATA_WIDTH-1:0] pkg);
    return pkg[CEP_LAST_SUBLINE_MSB:CEP_LAST_SUBLINE_LSB] != '0;
  endfunction

  // A package is legal on a channel only if that channel's own class bit is set.
  function automatic logic class_ok(input logic [CEP_DATA_WIDTH-1:0] pkg, input cep_ch_e ch);
    case (ch)
      CEP_CH_REQ:  return pkg[CEP_IS_REQ];
      CEP_CH_RESP: return pkg[CEP_IS_RESP];
      CEP_CH_INT:  return pkg[CEP_IS_INT];
      default:     return 1'b0;
    endcase
  endfunction

  function automatic cep_ch_e next_ch(input cep_ch_e ch);
    case (ch)
      CEP_CH_REQ:  return CEP_CH_RESP;
      CEP_CH_RESP: return CEP_CH_INT;
      default:     return CEP_CH_REQ;
    endcase
  endfunction

endpackage

// File: rtl/cep_tx_arbiter_fifo2.sv
// Two-entry in-order buffer between the arbiter and the link. The head register
// keeps its last value when the buffer drains.
module cep_fifo2 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [1:0]       count,
  output logic [WIDTH-1:0] head
);

  logic [WIDTH-1:0] head_q;
  logic [WIDTH-1:0] tail_q;
  logic [1:0]       count_q;
  logic             do_pop;
  logic             do_push;
  logic [1:0]       remain;

  always_comb begin
    do_pop  = pop && (count_q != 2'd0);
    do_push = push && ((count_q != 2'd2) || do_pop);
    remain  = count_q - {1'b0, do_pop};
  end

  // A push lands in whichever slot is the first free one after this cycle's pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= 2'd0;
    end else begin
      if (do_pop && (count_q == 2'd2)) begin
        head_q <= tail_q;
      end
      if (do_push) begin
        if (remain == 2'd0) begin
          head_q <= push_data;
        end else begin
          tail_q <= push_data;
        end
      end
      count_q <= remain + {1'b0, do_push};
    end
  end

  assign count = count_q;
  assign head  = head_q;

endmodule

// File: rtl/cep_tx_arbiter.sv
// Arbitrates the req/resp/int CEP sources onto one link, holding multi-subline
// messages together and flagging packages whose class bit disagrees with their channel.
module cep_tx_arbiter
  import cep_tx_arbiter_pkg::*;
#(
  parameter bit RR_EN = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CEP_DATA_WIDTH-1:0] req_pkg,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [CEP_DATA_WIDTH-1:0] resp_pkg,
  input  logic                      resp_valid,
  output logic                      resp_ready,
  input  logic [CEP_DATA_WIDTH-1:0] int_pkg,
  input  logic                      int_valid,
  output logic                      int_ready,
  output logic [CEP_DATA_WIDTH-1:0] out_pkg,
  output logic [CEP_CH_WIDTH-1:0]   out_src,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      locked,
  output logic [2:0]                err
);

  logic [2:0]                valid_vec;
  cep_ch_e                   rr_ptr;
  cep_ch_e                   lock_ch;
  cep_ch_e                   grant_ch;
  logic                      grant_any;
  logic                      locked_q;
  logic                      active;
  logic                      can_push;
  logic                      accept;
  logic [CEP_DATA_WIDTH-1:0] sel_pkg;
  logic [1:0]                count;
  logic [1:0]                cand;
  logic [CEP_CH_WIDTH+CEP_DATA_WIDTH-1:0] fifo_head;

  assign valid_vec = {int_valid, resp_valid, req_valid};

  // While locked the grant is pinned to the message owner, valid or not.
  always_comb begin
    grant_any = 1'b0;
    grant_ch  = CEP_CH_REQ;
    cand      = 2'd0;
    if (locked_q) begin
      grant_any = 1'b1;
      grant_ch  = lock_ch;
    end else if (RR_EN) begin
      for (int i = 0; i < 3; i++) begin
        cand = 2'((int'(rr_ptr) + i) % 3);
        if (!grant_any && valid_vec[cand]) begin
          grant_any = 1'b1;
          grant_ch  = cep_ch_e'(cand);
        end
      end
    end else if (int_valid) begin
      grant_any = 1'b1;
      grant_ch  = CEP_CH_INT;
    end else if (resp_valid) begin
      grant_any = 1'b1;
      grant_ch  = CEP_CH_RESP;
    end else if (req_valid) begin
      grant_any = 1'b1;
      grant_ch  = CEP_CH_REQ;
    end
  end

  always_comb begin
    can_push   = active && (count != 2'd2);
    req_ready  = grant_any && (grant_ch == CEP_CH_REQ)  && can_push;
    resp_ready = grant_any && (grant_ch == CEP_CH_RESP) && can_push;
    int_ready  = grant_any && (grant_ch == CEP_CH_INT)  && can_push;
    accept     = grant_any && valid_vec[grant_ch] && can_push;
    case (grant_ch)
      CEP_CH_RESP: sel_pkg = resp_pkg;
      CEP_CH_INT:  sel_pkg = int_pkg;
      default:     sel_pkg = req_pkg;
    endcase
  end

  // The pointer only advances at a message end so a locked message cannot be overtaken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active   <= 1'b0;
      locked_q <= 1'b0;
      lock_ch  <= CEP_CH_REQ;
      rr_ptr   <= CEP_CH_REQ;
      err      <= 3'b000;
    end else begin
      active <= 1'b1;
      if (accept) begin
        if (is_last(sel_pkg)) begin
          locked_q <= 1'b0;
          rr_ptr   <= next_ch(grant_ch);
        end else begin
          locked_q <= 1'b1;
          lock_ch  <= grant_ch;
        end
        if (!class_ok(sel_pkg, grant_ch)) begin
          err[grant_ch] <= 1'b1;
        end
      end
    end
  end

  cep_fifo2 #(
    .WIDTH(CEP_CH_WIDTH + CEP_DATA_WIDTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (accept),
    .push_data({grant_ch, sel_pkg}),
    .pop      (out_valid && out_ready),
    .count    (count),
    .head     (fifo_head)
  );

  assign out_valid = (count != 2'd0);
  assign out_pkg   = fifo_head[CEP_DATA_WIDTH-1:0];
  assign out_src   = fifo_head[CEP_CH_WIDTH+CEP_DATA_WIDTH-1:CEP_DATA_WIDTH];
  assign locked    = locked_q;

endmodule

// File: tb/tb_cep_tx_arbiter.sv
// Directed bench for cep_tx_arbiter: grant table for both arbitration modes plus
// hand-written lock, backpressure, class-check and reset sequences.
module tb_cep_tx_arbiter;
  import cep_tx_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] req_pkg, resp_pkg, int_pkg;
  logic        req_valid, resp_valid, int_valid;
  logic        out_ready;

  logic        req_ready, resp_ready, int_ready;
  logic [63:0] out_pkg;
  logic [1:0]  out_src;
  logic        out_valid, locked;
  logic [2:0]  err;

  logic        fp_req_ready, fp_resp_ready, fp_int_ready;
  logic [63:0] fp_out_pkg;
  logic [1:0]  fp_out_src;
  logic        fp_out_valid, fp_locked;
  logic [2:0]  fp_err;

  int checks = 0;
  int failures = 0;

  logic [1:0] mon_q[$];

  always #5 clk = ~clk;

  cep_tx_arbiter #(.RR_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_pkg(req_pkg), .req_valid(req_valid), .req_ready(req_ready),
    .resp_pkg(resp_pkg), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .int_pkg(int_pkg), .int_valid(int_valid), .int_ready(int_ready),
    .out_pkg(out_pkg), .out_src(out_src), .out_valid(out_valid), .out_ready(out_ready),
    .locked(locked), .err(err)
  );

  cep_tx_arbiter #(.RR_EN(1'b0)) dut_fp (
    .clk(clk), .rst_n(rst_n),
    .req_pkg(req_pkg), .req_valid(req_valid), .req_ready(fp_req_ready),
    .resp_pkg(resp_pkg), .resp_valid(resp_valid), .resp_ready(fp_resp_ready),
    .int_pkg(int_pkg), .int_valid(int_valid), .int_ready(fp_int_ready),
    .out_pkg(fp_out_pkg), .out_src(fp_out_src), .out_valid(fp_out_valid), .out_ready(out_ready),
    .locked(fp_locked), .err(fp_err)
  );

  // Records the source of every package that leaves the main DUT.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) mon_q.push_back(out_src);
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [63:0] mk_pkg(input int cls_bit, input logic [1:0] last, input logic [55:0] payload);
    logic [63:0] p;
    p = '0;
    p[63:8] = payload;
    p[1:0] = last;
    p[cls_bit] = 1'b1;
    return p;
  endfunction

  task automatic applyStimulus(input logic [2:0] v, input logic [63:0] rq, input logic [63:0] rs, input logic [63:0] it);
    req_valid  = v[0];
    resp_valid = v[1];
    int_valid  = v[2];
    req_pkg    = rq;
    resp_pkg   = rs;
    int_pkg    = it;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    out_ready = 1'b0;
    applyStimulus(3'b000, '0, '0, '0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [2:0] valid;
    logic [2:0] rr_ready;
    logic [2:0] fp_ready;
    logic [1:0] rr_ptr_after;
  } vec_t;

  vec_t vecs[8];

  logic [63:0] pr, ps, pi, p0, p1, p2, r1, r2, r3;
  int base;

  initial begin
    vecs[0] = '{3'b111, 3'b001, 3'b100, 2'd1};
    vecs[1] = '{3'b111, 3'b010, 3'b100, 2'd2};
    vecs[2] = '{3'b011, 3'b001, 3'b010, 2'd1};
    vecs[3] = '{3'b001, 3'b001, 3'b001, 2'd1};
    vecs[4] = '{3'b000, 3'b000, 3'b000, 2'd1};
    vecs[5] = '{3'b101, 3'b100, 3'b100, 2'd0};
    vecs[6] = '{3'b110, 3'b010, 3'b100, 2'd2};
    vecs[7] = '{3'b011, 3'b001, 3'b010, 2'd1};

    pr = mk_pkg(CEP_IS_REQ,  2'd1, 56'h11_0000);
    ps = mk_pkg(CEP_IS_RESP, 2'd1, 56'h22_0000);
    pi = mk_pkg(CEP_IS_INT,  2'd1, 56'h33_0000);

    // Reset state with all sources valid.
    rst_n = 1'b0;
    out_ready = 1'b1;
    applyStimulus(3'b111, pr, ps, pi);
    #12;
    checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
    checkOutput("reset_out_pkg", out_pkg, 64'd0);
    checkOutput("reset_out_src", 64'(out_src), 64'd0);
    checkOutput("reset_locked", 64'(locked), 64'd0);
    checkOutput("reset_err", 64'(err), 64'd0);
    checkOutput("reset_ready", 64'({int_ready, resp_ready, req_ready}), 64'd0);

    // Single package.
    doReset();
    out_ready = 1'b1;
    p0 = mk_pkg(CEP_IS_REQ, 2'd1, 56'hABCDEF_1234);
    applyStimulus(3'b001, p0, '0, '0);
    @(negedge clk);
    checkOutput("single_req_ready", 64'(req_ready), 64'd1);
    tick();
    applyStimulus(3'b000, '0, '0, '0);
    checkOutput("single_out_valid", 64'(out_valid), 64'd1);
    checkOutput("single_out_src", 64'(out_src), 64'd0);
    checkOutput("single_out_pkg", out_pkg, p0);
    checkOutput("single_rr_ptr", 64'(dut.rr_ptr), 64'd1);

    // Grant table for both arbitration modes.
    doReset();
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].valid, pr, ps, pi);
      @(negedge clk);
      checkOutput($sformatf("tbl%0d_rr_ready", i), 64'({int_ready, resp_ready, req_ready}), 64'(vecs[i].rr_ready));
      checkOutput($sformatf("tbl%0d_fp_ready", i), 64'({fp_int_ready, fp_resp_ready, fp_req_ready}), 64'(vecs[i].fp_ready));
      tick();
      checkOutput($sformatf("tbl%0d_rr_ptr", i), 64'(dut.rr_ptr), 64'(vecs[i].rr_ptr_after));
    end

    // Round-robin stream of single-subline packages.
    doReset();
    out_ready = 1'b1;
    applyStimulus(3'b111, pr, ps, pi);
    for (int k = 0; k < 6; k++) begin
      tick();
      checkOutput($sformatf("rr_seq%0d_valid", k), 64'(out_valid), 64'd1);
      checkOutput($sformatf("rr_seq%0d_src", k), 64'(out_src), 64'(k % 3));
    end
    applyStimulus(3'b000, '0, '0, '0);

    // Lock held across a two-cycle stall of the owning channel.
    doReset();
    out_ready = 1'b1;
    base = mon_q.size();
    r1 = mk_pkg(CEP_IS_RESP, 2'd0, 56'hA1);
    r2 = mk_pkg(CEP_IS_RESP, 2'd0, 56'hA2);
    r3 = mk_pkg(CEP_IS_RESP, 2'd2, 56'hA3);
    applyStimulus(3'b001, pr, '0, '0);
    tick();
    applyStimulus(3'b111, pr, r1, pi);
    @(negedge clk);
    checkOutput("lock_sub1_resp_ready", 64'(resp_ready), 64'd1);
    tick();
    checkOutput("lock_set", 64'(locked), 64'd1);
    applyStimulus(3'b101, pr, r1, pi);
    for (int g = 0; g < 2; g++) begin
      @(negedge clk);
      checkOutput($sformatf("lock_gap%0d_locked", g), 64'(locked), 64'd1);
      checkOutput($sformatf("lock_gap%0d_others", g), 64'({int_ready, req_ready}), 64'd0);
      tick();
    end
    applyStimulus(3'b111, pr, r2, pi);
    @(negedge clk);
    checkOutput("lock_sub2_resp_ready", 64'(resp_ready), 64'd1);
    tick();
    applyStimulus(3'b111, pr, r3, pi);
    tick();
    checkOutput("lock_cleared", 64'(locked), 64'd0);
    @(negedge clk);
    checkOutput("lock_after_int_ready", 64'(int_ready), 64'd1);
    tick();
    applyStimulus(3'b000, '0, '0, '0);
    repeat (3) tick();
    if (mon_q.size() < base + 5) begin
      checkOutput("lock_out_count", 64'(mon_q.size() - base), 64'd5);
    end else begin
      checkOutput("lock_out0", 64'(mon_q[base]),   64'd0);
      checkOutput("lock_out1", 64'(mon_q[base+1]), 64'd1);
      checkOutput("lock_out2", 64'(mon_q[base+2]), 64'd1);
      checkOutput("lock_out3", 64'(mon_q[base+3]), 64'd1);
      checkOutput("lock_out4", 64'(mon_q[base+4]), 64'd2);
    end

    // Backpressure fills the buffer, then drains in order.
    doReset();
    out_ready = 1'b0;
    p0 = mk_pkg(CEP_IS_REQ, 2'd1, 56'hB0);
    p1 = mk_pkg(CEP_IS_REQ, 2'd1, 56'hB1);
    p2 = mk_pkg(CEP_IS_REQ, 2'd1, 56'hB2);
    applyStimulus(3'b001, p0, '0, '0);
    @(negedge clk);
    checkOutput("bp_ready0", 64'(req_ready), 64'd1);
    tick();
    applyStimulus(3'b001, p1, '0, '0);
    @(negedge clk);
    checkOutput("bp_ready1", 64'(req_ready), 64'd1);
    tick();
    applyStimulus(3'b001, p2, '0, '0);
    @(negedge clk);
    checkOutput("bp_full_ready", 64'(req_ready), 64'd0);
    checkOutput("bp_full_count", 64'(dut.count), 64'd2);
    checkOutput("bp_head0", out_pkg, p0);
    tick();
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput("bp_pop_cycle_ready", 64'(req_ready), 64'd0);
    tick();
    @(negedge clk);
    checkOutput("bp_ready_back", 64'(req_ready), 64'd1);
    checkOutput("bp_head1", out_pkg, p1);
    tick();
    applyStimulus(3'b000, '0, '0, '0);
    checkOutput("bp_head2", out_pkg, p2);
    tick();
    checkOutput("bp_empty", 64'(out_valid), 64'd0);
    checkOutput("bp_hold_pkg", out_pkg, p2);

    // Class mismatch on the interrupt channel.
    doReset();
    out_ready = 1'b1;
    pi = mk_pkg(CEP_IS_RESP, 2'd1, 56'hC0);
    applyStimulus(3'b100, '0, '0, pi);
    tick();
    applyStimulus(3'b000, '0, '0, '0);
    checkOutput("cls_out_valid", 64'(out_valid), 64'd1);
    checkOutput("cls_out_src", 64'(out_src), 64'd2);
    checkOutput("cls_out_pkg", out_pkg, pi);
    checkOutput("cls_err", 64'(err), 64'b100);
    repeat (3) tick();
    checkOutput("cls_err_sticky", 64'(err), 64'b100);
    rst_n = 1'b0;
    #1;
    checkOutput("cls_err_reset", 64'(err), 64'd0);

    // Reset in the middle of a locked message.
    doReset();
    out_ready = 1'b0;
    applyStimulus(3'b001, mk_pkg(CEP_IS_REQ, 2'd0, 56'hD0), '0, '0);
    tick();
    applyStimulus(3'b000, '0, '0, '0);
    checkOutput("mid_locked", 64'(locked), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("mid_rst_locked", 64'(locked), 64'd0);
    checkOutput("mid_rst_count", 64'(dut.count), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    pi = mk_pkg(CEP_IS_INT, 2'd1, 56'hE0);
    applyStimulus(3'b100, '0, '0, pi);
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput("mid_int_ready", 64'(int_ready), 64'd1);
    tick();
    applyStimulus(3'b000, '0, '0, '0);
    checkOutput("mid_int_src", 64'(out_src), 64'd2);
    checkOutput("mid_int_pkg", out_pkg, pi);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
